player_crash_fsm: RTL and testbench

- Downstream consumer of the per-frame collision flags produced by the car collision stage.
- Samples the collision vector once per frame and turns sustained overlaps into single events.
- Runs the player's crash, spin, respawn and game-over state machine.
- Drives the lives count, the control-freeze/invulnerability/blink flags for player car logic and the sprite drawer, and one-cycle event pulses for the fuel and score logic.

---
 rtl/road_fighter_pkg.sv | 17 +
 rtl/frame_event_sampler.sv | 39 +++
 rtl/player_crash_fsm.sv | 179 +++++++++++++++++
 tb/tb_player_crash_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/road_fighter_pkg.sv
// Shared constants for the road fighter player logic: state encoding, collision bit map and the
// lives counter width.
package road_fighter_pkg;

    localparam int unsigned LIVES_W  = 3;

    localparam int unsigned COL_AI   = 0;
    localparam int unsigned COL_FUEL = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_DRIVE     = 2'd0;
    localparam state_t ST_SPIN      = 2'd1;
    localparam state_t ST_RESPAWN   = 2'd2;
    localparam state_t ST_GAME_OVER = 2'd3;

endpackage

// File: rtl/frame_event_sampler.sv
// Samples the per-frame collision flags on frame_start and reports only new (rising) overlaps,
// so a car sitting on an obstacle for many frames produces one event.
module frame_event_sampler
    import road_fighter_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       frame_start,
    input  logic       clear,
    input  logic [1:0] collisions,
    output logic       hit_evt,
    output logic       fuel_evt
);

    logic [1:0] prev_q, prev_d;
    logic [1:0] evt;

    always_comb begin
        prev_d = prev_q;
        if (clear) begin
            prev_d = '0;
        end else if (frame_start) begin
            prev_d = collisions;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign evt      = {2{frame_start}} & collisions & ~prev_q;
    assign hit_evt  = evt[COL_AI];
    assign fuel_evt = evt[COL_FUEL];

endmodule

// File: rtl/player_crash_fsm.sv
// Player crash / spin / respawn / game-over controller with lives and event pulses.
// Optional respawn blinking is built when RESPAWN_BLINK_EN is defined.
module player_crash_fsm
    import road_fighter_pkg::*;
#(
    parameter int unsigned SPIN_FRAMES    = 60,
    parameter int unsigned RESPAWN_FRAMES = 90,
    parameter int unsigned START_LIVES    = 3,
    parameter int unsigned BLINK_PERIOD   = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               frame_start,
    input  logic [1:0]         collisions,
    input  logic               restart,
    output logic [1:0]         state,
    output logic [LIVES_W-1:0] lives,
    output logic               freeze_control,
    output logic               invulnerable,
    output logic               blink,
    output logic               crash_pulse,
    output logic               respawn_pulse,
    output logic               fuel_pulse,
    output logic               game_over
);

    localparam int unsigned MAX_FRAMES = (SPIN_FRAMES > RESPAWN_FRAMES) ? SPIN_FRAMES
                                                                        : RESPAWN_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

    if (SPIN_FRAMES < 1 || RESPAWN_FRAMES < 1 || START_LIVES < 1 || START_LIVES > 7 ||
        BLINK_PERIOD < 1) begin : g_param_err
        $error("player_crash_fsm: parameter out of range");
    end

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               crash_q, crash_d;
    logic               respawn_q, respawn_d;
    logic               fuel_q, fuel_d;
    logic               hit_evt, fuel_evt;

    frame_event_sampler u_sampler (
        .clk         (clk),
        .resetN      (resetN),
        .frame_start (frame_start),
        .clear       (restart),
        .collisions  (collisions),
        .hit_evt     (hit_evt),
        .fuel_evt    (fuel_evt)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        crash_d   = 1'b0;
        respawn_d = 1'b0;
        fuel_d    = 1'b0;
        if (restart) begin
            state_d = ST_DRIVE;
            lives_d = LIVES_W'(START_LIVES);
            cnt_d   = '0;
        end else if (frame_start) begin
            unique case (state_q)
                ST_DRIVE: begin
                    if (hit_evt) begin
                        // Crash wins over a simultaneous pickup; the pickup is lost.
                        crash_d = 1'b1;
                        cnt_d   = '0;
                        if (lives_q > LIVES_W'(1)) begin
                            lives_d = lives_q - LIVES_W'(1);
                            state_d = ST_SPIN;
                        end else begin
                            lives_d = '0;
                            state_d = ST_GAME_OVER;
                        end
                    end else begin
                        fuel_d = fuel_evt;
                    end
                end
                ST_SPIN: begin
                    if (cnt_q == CNT_W'(SPIN_FRAMES - 1)) begin
                        respawn_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_RESPAWN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RESPAWN: begin
                    fuel_d = fuel_evt;
                    if (cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_DRIVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAME_OVER: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_DRIVE;
            lives_q   <= LIVES_W'(START_LIVES);
            cnt_q     <= '0;
            crash_q   <= 1'b0;
            respawn_q <= 1'b0;
            fuel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            cnt_q     <= cnt_d;
            crash_q   <= crash_d;
            respawn_q <= respawn_d;
            fuel_q    <= fuel_d;
        end
    end

`ifdef RESPAWN_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_PERIOD + 1);

    logic               blink_q, blink_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;

    always_comb begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (restart) begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end else if (respawn_d) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (frame_start && state_q == ST_RESPAWN) begin
            if (state_d != ST_RESPAWN) begin
                blink_d = 1'b0;
                bcnt_d  = '0;
            end else if (bcnt_q == BLINK_W'(BLINK_PERIOD - 1)) begin
                blink_d = ~blink_q;
                bcnt_d  = '0;
            end else begin
                bcnt_d = bcnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

    assign state          = state_q;
    assign lives          = lives_q;
    assign freeze_control = (state_q == ST_SPIN) || (state_q == ST_GAME_OVER);
    assign invulnerable   = (state_q == ST_RESPAWN);
    assign game_over      = (state_q == ST_GAME_OVER);
    assign crash_pulse    = crash_q;
    assign respawn_pulse  = respawn_q;
    assign fuel_pulse     = fuel_q;

endmodule

// File: tb/tb_player_crash_fsm.sv
// Randomized and directed bench for player_crash_fsm against a frame-level reference model.
module tb_player_crash_fsm;

    localparam int unsigned SPIN_F = 4;
    localparam int unsigned RESP_F = 6;
    localparam int unsigned LIVES0 = 3;
    localparam int unsigned BP     = 2;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       frame_start = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] collisions = 2'b00;
    logic [1:0] state;
    logic [2:0] lives;
    logic       freeze_control, invulnerable, blink;
    logic       crash_pulse, respawn_pulse, fuel_pulse, game_over;

    always #5 clk = ~clk;

    player_crash_fsm #(
        .SPIN_FRAMES    (SPIN_F),
        .RESPAWN_FRAMES (RESP_F),
        .START_LIVES    (LIVES0),
        .BLINK_PERIOD   (BP)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .frame_start    (frame_start),
        .collisions     (collisions),
        .restart        (restart),
        .state          (state),
        .lives          (lives),
        .freeze_control (freeze_control),
        .invulnerable   (invulnerable),
        .blink          (blink),
        .crash_pulse    (crash_pulse),
        .respawn_pulse  (respawn_pulse),
        .fuel_pulse     (fuel_pulse),
        .game_over      (game_over)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 drive, 1 spin, 2 respawn, 3 game over; timed phases count down
    int m_mode, m_lives, m_left, m_elapsed;
    bit m_ph, m_pf, m_crash, m_resp, m_fuel;

    task automatic model_reset();
        m_mode = 0; m_lives = LIVES0; m_left = 0; m_elapsed = 0;
        m_ph = 0; m_pf = 0; m_crash = 0; m_resp = 0; m_fuel = 0;
    endtask

    task automatic model_step(input bit fs, input logic [1:0] col, input bit rs);
        bit hit, fu;
        m_crash = 0; m_resp = 0; m_fuel = 0;
        if (rs) begin
            m_mode = 0; m_lives = LIVES0; m_left = 0; m_ph = 0; m_pf = 0;
        end else if (fs) begin
            hit = col[0] && !m_ph;
            fu  = col[1] && !m_pf;
            m_ph = col[0];
            m_pf = col[1];
            case (m_mode)
                0: begin
                    if (hit) begin
                        m_crash = 1;
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        if (m_lives == 0) m_mode = 3;
                        else begin m_mode = 1; m_left = SPIN_F; end
                    end else if (fu) m_fuel = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_resp = 1; m_mode = 2; m_left = RESP_F; m_elapsed = 0;
                    end
                end
                2: begin
                    m_fuel = fu;
                    m_left--;
                    m_elapsed++;
                    if (m_left == 0) m_mode = 0;
                end
                default: ;
            endcase
        end
    endtask

    function automatic bit exp_blink();
`ifdef RESPAWN_BLINK_EN
        return (m_mode == 2) && (((m_elapsed / BP) % 2) == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all();
        check("state", state, m_mode);
        check("lives", lives, m_lives);
        check("freeze_control", freeze_control, (m_mode == 1 || m_mode == 3));
        check("invulnerable", invulnerable, (m_mode == 2));
        check("game_over", game_over, (m_mode == 3));
        check("blink", blink, exp_blink());
        check("crash_pulse", crash_pulse, m_crash);
        check("respawn_pulse", respawn_pulse, m_resp);
        check("fuel_pulse", fuel_pulse, m_fuel);
    endtask

    task automatic cycle(input bit fs, input logic [1:0] col, input bit rs);
        @(negedge clk);
        frame_start = fs;
        collisions  = col;
        restart     = rs;
        model_step(fs, col, rs);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic frame(input logic [1:0] col, input int gap);
        repeat (gap) cycle(1'b0, col, 1'b0);
        cycle(1'b1, col, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        resetN      = 1'b0;
        frame_start = 1'b0;
        restart     = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        resetN = 1'b1;

        // Held hit: one crash, spin, respawn, then drive with no retrigger
        repeat (14) frame(2'b01, 1);
        frame(2'b00, 0);

        // Fuel pickups: two events, then none during spin
        repeat (3) frame(2'b10, 1);
        frame(2'b00, 1);
        frame(2'b10, 1);
        frame(2'b01, 0);
        frame(2'b10, 0);
        frame(2'b00, 0);
        frame(2'b10, 0);
        repeat (12) frame(2'b00, 1);

        // Three separated hits down to game over, then ignored hits
        cycle(1'b0, 2'b00, 1'b1);
        repeat (3) begin
            frame(2'b01, 0);
            repeat (11) frame(2'b00, 0);
        end
        repeat (3) begin
            frame(2'b01, 0);
            frame(2'b10, 0);
        end

        // Restart from game over, then simultaneous hit and fuel
        cycle(1'b0, 2'b00, 1'b1);
        frame(2'b11, 1);
        frame(2'b00, 1);
        // Restart mid-spin, also with a coincident frame_start
        cycle(1'b0, 2'b00, 1'b1);
        frame(2'b01, 0);
        frame(2'b00, 0);
        cycle(1'b0, 2'b00, 1'b1);
        frame(2'b01, 0);
        cycle(1'b1, 2'b01, 1'b1);
        frame(2'b01, 0);

        // Reach respawn, walk the blink pattern, then async reset mid-respawn
        cycle(1'b0, 2'b00, 1'b1);
        frame(2'b01, 0);
        repeat (7) frame(2'b00, 1);
        async_reset();
        frame(2'b00, 0);

        // Random traffic with lingering overlaps and back-to-back frame_starts
        begin
            logic [1:0] col = 2'b00;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(7) == 0) col = 2'($urandom_range(3));
                if ($urandom_range(999) == 0) async_reset();
                else cycle($urandom_range(2) == 0, col, $urandom_range(299) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
